// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-style datapath: sequences fetch, decode and
// per-class execute/writeback states and drives the datapath enables and selects.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       zeroext,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [4:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    Fetch   = 4'd0,
    Decode  = 4'd1,
    MemAdr  = 4'd2,
    MemRd   = 4'd3,
    MemWb   = 4'd4,
    MemWr   = 4'd5,
    RtypeEx = 4'd6,
    AluWb   = 4'd7,
    Branch  = 4'd8,
    ImmEx   = 4'd9,
    ImmWb   = 4'd10,
    Jump    = 4'd11
  } state_e;

  localparam logic [5:0] OpLw = 6'b100011, OpSw = 6'b101011, OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpJ = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000, OpAndi = 6'b001100, OpOri = 6'b001101;
  localparam logic [5:0] OpSlti = 6'b001010, OpLui = 6'b001111;

  localparam logic [4:0] AluAdd = 5'b00010, AluSub = 5'b00110, AluAnd = 5'b00000;
  localparam logic [4:0] AluOr = 5'b00001, AluSlt = 5'b00111, AluXor = 5'b00101;
  localparam logic [4:0] AluSll = 5'b01110, AluSrl = 5'b01000, AluSra = 5'b11001;
  localparam logic [4:0] AluLui = 5'b00011;

  state_e state_q, state_d;
  logic   pcen_raw, irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;
  logic [4:0] r_alu, i_alu;
  logic       r_ok, i_ze;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= Fetch;
    else       state_q <= state_d;
  end

  always_comb begin
    r_ok  = 1'b1;
    r_alu = AluAnd;
    case (funct)
      6'b100000: r_alu = AluAdd;
      6'b100010: r_alu = AluSub;
      6'b100100: r_alu = AluAnd;
      6'b100101: r_alu = AluOr;
      6'b100110: r_alu = AluXor;
      6'b101010: r_alu = AluSlt;
      6'b000000: r_alu = AluSll;
      6'b000010: r_alu = AluSrl;
      6'b000011: r_alu = AluSra;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_ze  = 1'b0;
    i_alu = AluAdd;
    case (op)
      OpAndi: begin i_alu = AluAnd; i_ze = 1'b1; end
      OpOri:  begin i_alu = AluOr;  i_ze = 1'b1; end
      OpSlti: i_alu = AluSlt;
      OpLui:  i_alu = AluLui;
      default: i_alu = AluAdd;
    endcase
  end

  always_comb begin
    state_d      = Fetch;
    pcen_raw     = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    zeroext      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = 5'b00000;
    case (state_q)
      Fetch: begin
        irwrite_raw = 1'b1;
        pcen_raw    = 1'b1;
        alusrcb     = 2'b01;
        alucontrol  = AluAdd;
        state_d     = Decode;
      end
      Decode: begin
        alusrcb    = 2'b11;
        alucontrol = AluAdd;
        case (op)
          OpLw, OpSw:                            state_d = MemAdr;
          OpRtype:                               state_d = RtypeEx;
          OpBeq, OpBne:                          state_d = Branch;
          OpAddi, OpAndi, OpOri, OpSlti, OpLui:  state_d = ImmEx;
          OpJ:                                   state_d = Jump;
          default: begin
            illegal_raw = 1'b1;
            state_d     = Fetch;
          end
        endcase
      end
      MemAdr: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = AluAdd;
        state_d    = (op == OpLw) ? MemRd : MemWr;
      end
      MemRd: begin
        iord    = 1'b1;
        state_d = MemWb;
      end
      MemWb: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      MemWr: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      RtypeEx: begin
        alusrca     = 1'b1;
        alucontrol  = r_alu;
        illegal_raw = ~r_ok;
        state_d     = r_ok ? AluWb : Fetch;
      end
      AluWb: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      Branch: begin
        alusrca    = 1'b1;
        alucontrol = AluSub;
        pcsrc      = 2'b01;
        // Mealy: the branch decision follows zero within the cycle.
        pcen_raw   = (op == OpBne) ? ~zero : zero;
      end
      ImmEx: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = i_alu;
        zeroext    = i_ze;
        state_d    = ImmWb;
      end
      ImmWb: begin
        regwrite_raw = 1'b1;
        alucontrol   = i_alu;
        zeroext      = i_ze;
      end
      Jump: begin
        pcsrc    = 2'b10;
        pcen_raw = 1'b1;
      end
      default: state_d = Fetch;
    endcase
  end

  // State is already Fetch during reset; only the side-effecting strobes need gating.
  assign pcen     = pcen_raw & ~reset;
  assign irwrite  = irwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign illegal  = illegal_raw & ~reset;
  assign state    = state_q;

endmodule
